ibutterfly_stream: RTL and testbench

Streaming radix-4 inverse butterfly for the 16-point FFT datapath. It accepts four complex samples serially (A, B, C, D order) over a valid/ready interface and computes the 4-point inverse DFT with 1/4 scaling. It returns the four results serially in natural order (out0..out3). It sits on the inverse path, undoing the forward radix-4 stage, so forward-stage outputs round-trip back to the original samples.

---
 rtl/ibutterfly_stream.sv | 163 ++++++++++++++++
 tb/tb_ibutterfly_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibutterfly_stream.sv
// ibutterfly_stream: serial 4-point inverse DFT (radix-4 inverse butterfly) with 1/4 scaling.
// Optional: define IBFLY_ROUND_EN to round half toward +inf instead of truncating.
module ibutterfly_stream (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_re,
    input  logic signed [15:0] in_im,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_re,
    output logic signed [15:0] out_im,
    output logic [1:0]         out_idx,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_COMPUTE = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

`ifdef IBFLY_ROUND_EN
    localparam logic signed [17:0] RND = 18'sd2;
`else
    localparam logic signed [17:0] RND = 18'sd0;
`endif

    state_t             state_q;
    logic [1:0]         cnt_q;
    logic [1:0]         ocnt_q;
    logic [1:0]         ocnt_nx;
    logic signed [15:0] smp_re_q [4];
    logic signed [15:0] smp_im_q [4];
    logic signed [15:0] y_re_q [4];
    logic signed [15:0] y_im_q [4];
    logic signed [15:0] y_re_d [4];
    logic signed [15:0] y_im_d [4];
    logic signed [15:0] out_re_q;
    logic signed [15:0] out_im_q;

    logic signed [17:0] ar, ai, br, bi, cr, ci, dr, di;
    logic signed [17:0] sum_re [4];
    logic signed [17:0] sum_im [4];
    logic signed [17:0] sh_re [4];
    logic signed [17:0] sh_im [4];
    logic               unused_hi;

    logic acc_in;

    assign acc_in  = (state_q == S_COLLECT) && in_valid;
    assign ocnt_nx = ocnt_q + 2'd1;

    // Sign-extend the stored samples to the 18-bit sum width
    assign ar = {{2{smp_re_q[0][15]}}, smp_re_q[0]};
    assign ai = {{2{smp_im_q[0][15]}}, smp_im_q[0]};
    assign br = {{2{smp_re_q[1][15]}}, smp_re_q[1]};
    assign bi = {{2{smp_im_q[1][15]}}, smp_im_q[1]};
    assign cr = {{2{smp_re_q[2][15]}}, smp_re_q[2]};
    assign ci = {{2{smp_im_q[2][15]}}, smp_im_q[2]};
    assign dr = {{2{smp_re_q[3][15]}}, smp_re_q[3]};
    assign di = {{2{smp_im_q[3][15]}}, smp_im_q[3]};

    // Inverse butterfly sums, scaled by 1/4 with optional rounding
    always_comb begin
        sum_re[0] = ar + br + cr + dr;
        sum_im[0] = ai + bi + ci + di;
        sum_re[1] = ar - bi - cr + di;
        sum_im[1] = ai + br - ci - dr;
        sum_re[2] = ar - br + cr - dr;
        sum_im[2] = ai - bi + ci - di;
        sum_re[3] = ar + bi - cr - di;
        sum_im[3] = ai - br - ci + dr;
        unused_hi = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sh_re[k]  = (sum_re[k] + RND) >>> 2;
            sh_im[k]  = (sum_im[k] + RND) >>> 2;
            y_re_d[k] = sh_re[k][15:0];
            y_im_d[k] = sh_im[k][15:0];
            unused_hi = unused_hi ^ (^sh_re[k][17:16]) ^ (^sh_im[k][17:16]);
        end
    end

    // Sample slots A..D, written only while collecting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                smp_re_q[k] <= '0;
                smp_im_q[k] <= '0;
            end
        end else if (!flush && acc_in) begin
            smp_re_q[cnt_q] <= in_re;
            smp_im_q[cnt_q] <= in_im;
        end
    end

    // Control FSM with registered results and output data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_COLLECT;
            cnt_q    <= '0;
            ocnt_q   <= '0;
            out_re_q <= '0;
            out_im_q <= '0;
            for (int k = 0; k < 4; k++) begin
                y_re_q[k] <= '0;
                y_im_q[k] <= '0;
            end
        end else if (flush) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
            ocnt_q  <= '0;
        end else begin
            unique case (state_q)
                S_COLLECT: begin
                    if (in_valid) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= S_COMPUTE;
                        end
                    end
                end
                S_COMPUTE: begin
                    for (int k = 0; k < 4; k++) begin
                        y_re_q[k] <= y_re_d[k];
                        y_im_q[k] <= y_im_d[k];
                    end
                    out_re_q <= y_re_d[0];
                    out_im_q <= y_im_d[0];
                    ocnt_q   <= '0;
                    state_q  <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (ocnt_q == 2'd3) begin
                            ocnt_q  <= '0;
                            state_q <= S_COLLECT;
                        end else begin
                            ocnt_q   <= ocnt_nx;
                            out_re_q <= y_re_q[ocnt_nx];
                            out_im_q <= y_im_q[ocnt_nx];
                        end
                    end
                end
                default: begin
                    state_q <= S_COLLECT;
                    cnt_q   <= '0;
                    ocnt_q  <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_COLLECT);
    assign out_valid = (state_q == S_EMIT);
    assign out_idx   = ocnt_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign busy      = (state_q != S_COLLECT) || (cnt_q != 2'd0);

endmodule

// File: tb/tb_ibutterfly_stream.sv
// tb_ibutterfly_stream: directed checks of the streaming inverse butterfly.
// Honours IBFLY_ROUND_EN for the rounding vector.
module tb_ibutterfly_stream;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_re;
    logic signed [15:0] in_im;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;
    logic [1:0]         out_idx;
    logic               busy;

    int n_chk  = 0;
    int n_fail = 0;

    ibutterfly_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int re, input int im);
        int t;
        t        = 0;
        in_re    = 16'(re);
        in_im    = 16'(im);
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input int er, input int ei,
                        input int eidx);
        int t;
        t         = 0;
        out_ready = 1'b1;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_re"}, out_re, er);
        check({tag, "_im"}, out_im, ei);
        check({tag, "_idx"}, out_idx, eidx);
        @(posedge clk);
        #1;
    endtask

    task automatic send_rt();
        send(1000, 0);
        send(-200, 200);
        send(-200, 0);
        send(-200, -200);
    endtask

    task automatic send_dc();
        send(100, 0);
        send(100, 0);
        send(100, 0);
        send(100, 0);
    endtask

    task automatic recv_dc(input string tag);
        recv({tag, "0"}, 100, 0, 0);
        recv({tag, "1"}, 0, 0, 1);
        recv({tag, "2"}, 0, 0, 2);
        recv({tag, "3"}, 0, 0, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_re     = '0;
        in_im     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_re", out_re, 0);
        check("rst_out_im", out_im, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round trip with latency check
        send_rt();
        check("rt_lat_ov0", out_valid, 0);
        check("rt_lat_rdy0", in_ready, 0);
        check("rt_lat_busy", busy, 1);
        @(posedge clk);
        #1;
        check("rt_lat_ov1", out_valid, 1);
        recv("rt0", 100, 0, 0);
        recv("rt1", 200, 0, 1);
        recv("rt2", 300, 0, 2);
        recv("rt3", 400, 0, 3);
        check("rt_end_ov", out_valid, 0);
        check("rt_end_rdy", in_ready, 1);
        check("rt_end_busy", busy, 0);

        // DC input with gaps between samples
        send(100, 0);
        repeat (3) begin
            @(negedge clk);
            check("gap_busy", busy, 1);
            check("gap_rdy", in_ready, 1);
        end
        send(100, 0);
        repeat (2) @(negedge clk);
        send(100, 0);
        send(100, 0);
        recv_dc("dc");

        // Backpressure at ocnt=1
        send_rt();
        recv("bp0", 100, 0, 0);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_ov", out_valid, 1);
            check("bp_idx", out_idx, 1);
            check("bp_re", out_re, 200);
            check("bp_im", out_im, 0);
            check("bp_rdy", in_ready, 0);
        end
        recv("bp1", 200, 0, 1);
        recv("bp2", 300, 0, 2);
        recv("bp3", 400, 0, 3);

        // Rounding vector
        send(3, -3);
        send(0, 0);
        send(0, 0);
        send(0, 0);
`ifdef IBFLY_ROUND_EN
        for (int k = 0; k < 4; k++) recv("rnd", 1, -1, k);
`else
        for (int k = 0; k < 4; k++) recv("rnd", 0, -1, k);
`endif

        // Flush after two samples, with a simultaneous input beat
        send(5000, 7);
        send(123, -9);
        check("pre_flush_busy", busy, 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_re    = 16'sd999;
        in_im    = 16'sd999;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_rdy", in_ready, 1);
        check("flush_ov", out_valid, 0);
        send(400, 0);
        send(0, 0);
        send(0, 0);
        send(0, 0);
        for (int k = 0; k < 4; k++) recv("fl", 100, 0, k);

        // Asynchronous reset during EMIT
        send_rt();
        recv("ar0", 100, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_ov", out_valid, 0);
        check("ar_rdy", in_ready, 1);
        check("ar_busy", busy, 0);
        check("ar_idx", out_idx, 0);
        check("ar_re", out_re, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_dc();
        recv_dc("post");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
